ahb_display_scan: RTL and testbench

AHB-Lite slave that owns the four-digit multiplexed seven-segment display and sequences it: it time-slices the shared segment bus across the four digit strobes, inserts a programmable blanking gap at each digit change, and double-buffers the digit patterns so that firmware updates never tear mid-frame. It sits on the SoC AHB interconnect as an extra slave and drives SegA–SegG, DP and nDigit directly to the pads.

---
 rtl/ahb_display_scan.sv | 216 +++++++++++++++++++++
 tb/tb_ahb_display_scan.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ahb_display_scan.sv
// Purpose: AHB-Lite slave that multiplexes four double-buffered seven-segment digits onto the pads.
// Latency: register writes land at the end of the data phase; pad outputs trail scan state by one cycle.
// Backpressure: none; HREADYOUT is tied high and every access completes in one data-phase cycle.
//
// Ports:
//   HCLK, HRESETn            clock and synchronous active-low reset
//   HSEL, HADDR, HWDATA,     AHB-Lite slave request (only HADDR[4:2] decoded,
//   HSIZE, HTRANS, HWRITE,   HSIZE ignored)
//   HREADY
//   HRDATA, HREADYOUT        AHB-Lite slave response
//   SegA..SegG, DP           active-high segment drives
//   nDigit[3:0]              active-low digit strobes
module ahb_display_scan #(
  parameter logic [15:0] DIV_RESET   = 16'd4999,
  parameter logic [3:0]  BLANK_RESET = 4'd1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        SegA,
  output logic        SegB,
  output logic        SegC,
  output logic        SegD,
  output logic        SegE,
  output logic        SegF,
  output logic        SegG,
  output logic        DP,
  output logic [3:0]  nDigit
);

  typedef enum logic [1:0] {
    PH_OFF   = 2'd0,
    PH_BLANK = 2'd1,
    PH_ON    = 2'd2
  } phase_t;

  // Bus data-phase tracking
  logic        r_dp_vld;
  logic        r_dp_write;
  logic [2:0]  r_dp_addr;

  // Programmable state
  logic [7:0]  r_shadow [4];
  logic [7:0]  r_active [4];
  logic        r_en;
  logic [3:0]  r_blank;
  logic [15:0] r_div;
  logic        r_pending;

  // Scan state
  logic [15:0] r_div_cur;   // slot length latched at slot start
  logic [15:0] r_cnt;
  logic [1:0]  r_idx;
  logic [7:0]  r_frame;

  // Registered pad drives
  logic [3:0]  r_ndig;
  logic [7:0]  r_seg;

  phase_t      w_phase;
  logic [15:0] w_cnt_nxt;
  logic [1:0]  w_idx_nxt;
  logic [15:0] w_div_cur_nxt;
  logic        w_frame_end;
  logic        w_wr;
  logic        w_wr_digit;
  logic        w_wr_ctrl;
  logic        w_wr_div;
  logic [15:0] w_div_wdata;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_unused = ^{HSIZE, HADDR[31:5], HADDR[1:0], HWDATA[31:16], HTRANS[0]};

  // Data-phase write decode
  assign w_wr        = r_dp_vld & r_dp_write;
  assign w_wr_digit  = w_wr & ~r_dp_addr[2];
  assign w_wr_ctrl   = w_wr & (r_dp_addr == 3'd4);
  assign w_wr_div    = w_wr & (r_dp_addr == 3'd5);
  assign w_div_wdata = (HWDATA[15:0] < 16'd3) ? 16'd3 : HWDATA[15:0];

  // Scan next-state: the phase is decoded from the slot counter so a BLANK
  // write changes the current slot's gap immediately.
  always_comb begin
    w_phase       = PH_OFF;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_div_cur_nxt = r_div_cur;
    w_frame_end   = 1'b0;
    if (!r_en) begin
      w_cnt_nxt     = 16'd0;
      w_idx_nxt     = 2'd0;
      w_div_cur_nxt = r_div;
    end else begin
      w_phase = ({12'd0, r_blank} > r_cnt) ? PH_BLANK : PH_ON;
      if (r_cnt == r_div_cur) begin
        w_cnt_nxt     = 16'd0;
        w_idx_nxt     = r_idx + 2'd1;
        w_div_cur_nxt = r_div;           // new DIV only at a slot start
        w_frame_end   = (r_idx == 2'd3);
      end else begin
        w_cnt_nxt = r_cnt + 16'd1;
      end
    end
  end

  // Bus and register file
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_dp_vld   <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= 3'd0;
      r_en       <= 1'b0;
      r_blank    <= BLANK_RESET;
      r_div      <= DIV_RESET;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= 8'd0;
      end
    end else begin
      if (HREADY) begin
        r_dp_vld <= HSEL & HTRANS[1];
        if (HSEL & HTRANS[1]) begin
          r_dp_addr  <= HADDR[4:2];
          r_dp_write <= HWRITE;
        end
      end
      if (w_wr_digit) begin
        r_shadow[r_dp_addr[1:0]] <= HWDATA[7:0];
      end
      if (w_wr_ctrl) begin
        r_en    <= HWDATA[0];
        r_blank <= HWDATA[7:4];
      end
      if (w_wr_div) begin
        r_div <= w_div_wdata;
      end
    end
  end

  // Scan state, double buffer and pads
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_cnt     <= 16'd0;
      r_idx     <= 2'd0;
      r_div_cur <= DIV_RESET;
      r_frame   <= 8'd0;
      r_pending <= 1'b0;
      r_ndig    <= 4'hF;
      r_seg     <= 8'd0;
      for (int i = 0; i < 4; i++) begin
        r_active[i] <= 8'd0;
      end
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_div_cur <= w_div_cur_nxt;
      if (!r_en) begin
        for (int i = 0; i < 4; i++) begin
          r_active[i] <= r_shadow[i];
        end
        r_pending <= 1'b0;
      end else begin
        if (w_frame_end) begin
          r_frame <= r_frame + 8'd1;
          // Commit takes the pre-write shadow; a coincident digit write
          // keeps PENDING set so it commits next frame.
          if (r_pending) begin
            for (int i = 0; i < 4; i++) begin
              r_active[i] <= r_shadow[i];
            end
          end
        end
        if (w_wr_digit) begin
          r_pending <= 1'b1;
        end else if (w_frame_end) begin
          r_pending <= 1'b0;
        end
      end
      r_ndig <= (w_phase == PH_ON) ? ~(4'b0001 << r_idx) : 4'hF;
      r_seg  <= (w_phase == PH_ON) ? r_active[r_idx] : 8'd0;
    end
  end

  // Read mux, driven only during a read data phase
  always_comb begin
    w_rdata = 32'd0;
    case (r_dp_addr)
      3'd0, 3'd1, 3'd2, 3'd3: w_rdata = {24'd0, r_shadow[r_dp_addr[1:0]]};
      3'd4:                   w_rdata = {24'd0, r_blank, 3'd0, r_en};
      3'd5:                   w_rdata = {16'd0, r_div};
      3'd6:                   w_rdata = {16'd0, r_frame, 4'd0, (w_phase == PH_BLANK), r_pending, r_idx};
      default:                w_rdata = 32'd0;
    endcase
  end

  assign HRDATA    = (r_dp_vld & ~r_dp_write) ? w_rdata : 32'd0;
  assign HREADYOUT = 1'b1;
  assign SegA      = r_seg[0];
  assign SegB      = r_seg[1];
  assign SegC      = r_seg[2];
  assign SegD      = r_seg[3];
  assign SegE      = r_seg[4];
  assign SegF      = r_seg[5];
  assign SegG      = r_seg[6];
  assign DP        = r_seg[7];
  assign nDigit    = r_ndig;

endmodule

// File: tb/tb_ahb_display_scan.sv
// Purpose: directed self-checking bench for ahb_display_scan.
// Latency: expectations are indexed by cycles since the EN 0->1 edge.
// Backpressure: HREADY held high; the slave never stalls.
module tb_ahb_display_scan;

  logic        HCLK;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP;
  logic [3:0]  nDigit;
  logic [7:0]  seg;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int en_cyc = 0;
  logic [31:0] rd;
  logic [7:0]  pat [4] = '{8'h3F, 8'h06, 8'h5B, 8'h4F};

  assign seg = {DP, SegG, SegF, SegE, SegD, SegC, SegB, SegA};

  ahb_display_scan #(.DIV_RESET(16'd4999), .BLANK_RESET(4'd1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .SegA(SegA), .SegB(SegB), .SegC(SegC), .SegD(SegD), .SegE(SegE),
    .SegF(SegF), .SegG(SegG), .DP(DP), .nDigit(nDigit)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the edge that ends the data phase.
  task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
    #3;
    data = HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic wait_to(input int k);
    while (cyc - en_cyc < k) begin
      @(posedge HCLK); #1;
    end
  endtask

  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HWDATA = 32'd0;
    HSIZE = 3'b010; HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;

    // Reset state
    chk("rst_ndigit", {28'd0, nDigit}, 32'hF);
    chk("rst_seg", {24'd0, seg}, 32'h0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    chk("rst_hrdata", HRDATA, 32'h0);
    for (int a = 0; a < 4; a++) begin
      ahb_read(32'(a * 4), rd);
      chk("rst_digit", rd, 32'h0);
    end
    ahb_read(32'h10, rd); chk("rst_ctrl", rd, 32'h10);
    ahb_read(32'h14, rd); chk("rst_div", rd, 32'd4999);
    ahb_read(32'h18, rd); chk("rst_status", rd, 32'h0);
    ahb_read(32'h1C, rd); chk("rst_unmapped", rd, 32'h0);

    // Program DIV=3, patterns, then enable with BLANK=1
    ahb_write(32'h14, 32'd3);
    for (int a = 0; a < 4; a++) ahb_write(32'(a * 4), {24'd0, pat[a]});
    ahb_write(32'h10, 32'h11);
    en_cyc = cyc;

    // First frame: pads at k reflect scan cycle k-1
    for (int k = 1; k <= 16; k++) begin
      wait_to(k);
      if ((k - 1) % 4 == 0) begin
        chk("f0_ndigit_blank", {28'd0, nDigit}, 32'hF);
        chk("f0_seg_blank", {24'd0, seg}, 32'h0);
      end else begin
        chk("f0_ndigit_on", {28'd0, nDigit}, {28'd0, ~(4'b0001 << ((k - 1) / 4))});
        chk("f0_seg_on", {24'd0, seg}, {24'd0, pat[(k - 1) / 4]});
      end
    end

    // Mid-frame DIGIT2 update (lands at k=18)
    ahb_write(32'h08, 32'h7F);
    ahb_read(32'h18, rd); chk("status_pending_f1", rd, 32'h0104);
    wait_to(27);
    chk("f1_d2_ndigit", {28'd0, nDigit}, 32'hB);
    chk("f1_d2_old_seg", {24'd0, seg}, 32'h5B);
    wait_to(43);
    chk("f2_d2_new_seg", {24'd0, seg}, 32'h7F);

    // DIGIT0 mid-frame, then DIGIT1 exactly on the frame-2 boundary (edge 48)
    ahb_write(32'h00, 32'h77);
    wait_to(46);
    ahb_write(32'h04, 32'h66);
    ahb_read(32'h18, rd); chk("status_boundary_write", rd, 32'h0304);
    wait_to(51);
    chk("f3_d0_ndigit", {28'd0, nDigit}, 32'hE);
    chk("f3_d0_seg", {24'd0, seg}, 32'h77);
    wait_to(55);
    chk("f3_d1_old_seg", {24'd0, seg}, 32'h06);
    wait_to(71);
    chk("f4_d1_new_seg", {24'd0, seg}, 32'h66);
    ahb_read(32'h18, rd); chk("status_f4_blank", rd, 32'h040A);

    // EN cleared mid-ON of digit 2 (CTRL updates at edge 75)
    ahb_write(32'h10, 32'h10);
    chk("dis_still_lit_ndigit", {28'd0, nDigit}, 32'hB);
    chk("dis_still_lit_seg", {24'd0, seg}, 32'h7F);
    @(posedge HCLK); #1;
    chk("dis_dark_ndigit", {28'd0, nDigit}, 32'hF);
    chk("dis_dark_seg", {24'd0, seg}, 32'h0);
    ahb_read(32'h18, rd); chk("status_off", rd, 32'h0400);

    // DIV clamp
    ahb_write(32'h14, 32'd1);
    ahb_read(32'h14, rd); chk("div_clamp", rd, 32'd3);
    ahb_read(32'h10, rd); chk("ctrl_off", rd, 32'h10);

    // BLANK=15 with DIV=3: permanently dark, idx still cycles
    ahb_write(32'h10, 32'hF1);
    en_cyc = cyc;
    ahb_read(32'h18, rd); chk("blank15_status_a", rd, 32'h0408);
    wait_to(13);
    ahb_read(32'h18, rd); chk("blank15_status_b", rd, 32'h040B);
    for (int k = 16; k <= 23; k++) begin
      wait_to(k);
      chk("blank15_ndigit", {28'd0, nDigit}, 32'hF);
    end
    ahb_read(32'h18, rd); chk("blank15_status_c", rd, 32'h050A);

    // Reset in the middle of an ON phase
    ahb_write(32'h10, 32'h10);
    ahb_write(32'h10, 32'h11);
    en_cyc = cyc;
    wait_to(2);
    chk("prerst_ndigit", {28'd0, nDigit}, 32'hE);
    chk("prerst_seg", {24'd0, seg}, 32'h77);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    chk("rst2_ndigit", {28'd0, nDigit}, 32'hF);
    chk("rst2_seg", {24'd0, seg}, 32'h0);
    chk("rst2_hreadyout", {31'd0, HREADYOUT}, 32'h1);
    repeat (5) begin
      @(posedge HCLK); #1;
    end
    chk("rst2_stays_off", {28'd0, nDigit}, 32'hF);
    ahb_read(32'h10, rd); chk("rst2_ctrl", rd, 32'h10);
    ahb_read(32'h00, rd); chk("rst2_digit0", rd, 32'h0);
    ahb_read(32'h14, rd); chk("rst2_div", rd, 32'd4999);
    ahb_read(32'h18, rd); chk("rst2_status", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
